keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/keypad_scanner.sv | 152 +++++++++++++++
 tb/tb_keypad_scanner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   - matrix geometry (NUM_ROWS, NUM_COLS)
//   - default timing parameters (dwell per column, debounce depth)
//   - scanner state encoding
//   - small helpers for row priority and column drive patterns
package keypad_pkg;

   localparam int NUM_ROWS           = 4;
   localparam int NUM_COLS           = 4;
   localparam int DWELL_CYCLES_DEF   = 4;
   localparam int DEBOUNCE_COUNT_DEF = 3;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } scan_state_e;

   // Lowest-numbered low row wins. Walking from the top down lets the
   // last assignment (row 0) take priority.
   function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] rows);
      logic [1:0] sel;
      sel = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (!rows[i]) sel = 2'(i);
      end
      return sel;
   endfunction

   // Active-low one-cold column pattern for a column index.
   function automatic logic [NUM_COLS-1:0] col_mask(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk  - destination clock
//   rst  - asynchronous active-high reset, both flops load RESET_VALUE
//   d    - asynchronous input bus
//   q    - synchronized output, two clk edges behind d
// Each bit is synchronized independently; only use it for levels that are
// sampled long after they settle (no multi-bit coherence is implied).
module sync_2ff #(
   parameter int                WIDTH       = 4,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning 4x4 keypad decoder with debounce.
//   slow_clock - the only clock, rising edge
//   reset      - asynchronous active-high reset
//   row_in     - raw active-low rows, asynchronous (pulled up)
//   col_drive  - active-low column drive, exactly one bit low
//   key_code   - last accepted key, col*4 + row
//   key_valid  - one-cycle pulse when a new key is accepted
//   key_held   - high while the accepted key is still pressed
//   state_dbg  - current scanner state, for observation only
//
// Output protocol: key_valid is a single-cycle strobe with no back-pressure;
// key_code is valid from that cycle on and holds until the next strobe.
//
// Each column is driven for DWELL_CYCLES cycles. Rows are only looked at on
// the last cycle of the dwell (the sample point), which leaves time for the
// two synchronizer flops to settle after the column changes.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int DWELL_CYCLES   = DWELL_CYCLES_DEF,
   parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF
) (
   input  logic        slow_clock,
   input  logic        reset,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_drive,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output scan_state_e state_dbg
);

   localparam int DW = $clog2(DWELL_CYCLES);
   localparam int MW = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_COUNT);

   scan_state_e   state;
   logic [1:0]    col_idx;
   logic [DW-1:0] dwell_cnt;
   logic [MW-1:0] match_cnt;
   logic [3:0]    cand_code;
   logic [3:0]    rows_sync;

   logic          sample_pt;
   logic          any_low;
   logic [3:0]    code_now;
   logic [1:0]    col_next;
   logic [MW-1:0] match_inc;

   sync_2ff #(
      .WIDTH       (NUM_ROWS),
      .RESET_VALUE (4'b1111)
   ) u_row_sync (
      .clk (slow_clock),
      .rst (reset),
      .d   (row_in),
      .q   (rows_sync)
   );

   assign sample_pt = (dwell_cnt == DWELL_LAST);
   assign any_low   = (rows_sync != 4'b1111);
   assign code_now  = {col_idx, first_low_row(rows_sync)};
   assign col_next  = col_idx + 2'd1;
   assign match_inc = match_cnt + 1'b1;
   assign state_dbg = state;

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state     <= ST_SCAN;
         col_idx   <= 2'd0;
         col_drive <= 4'b1110;
         dwell_cnt <= '0;
         match_cnt <= '0;
         cand_code <= 4'h0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         // Dwell counter never stops, so sample spacing is constant even
         // while the column is frozen.
         dwell_cnt <= sample_pt ? '0 : dwell_cnt + 1'b1;

         if (sample_pt) begin
            case (state)
               ST_SCAN: begin
                  if (any_low) begin
                     cand_code <= code_now;
                     match_cnt <= MW'(1);
                     state     <= ST_DEBOUNCE;
                  end else begin
                     col_idx   <= col_next;
                     col_drive <= col_mask(col_next);
                  end
               end

               ST_DEBOUNCE: begin
                  // Column is frozen, so equal codes mean the same row.
                  if (any_low && (code_now == cand_code)) begin
                     if (match_inc == MATCH_DONE) begin
                        key_code  <= cand_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        match_cnt <= '0;
                        state     <= ST_HELD;
                     end else begin
                        match_cnt <= match_inc;
                     end
                  end else begin
                     match_cnt <= '0;
                     state     <= ST_SCAN;
                     col_idx   <= col_next;
                     col_drive <= col_mask(col_next);
                  end
               end

               ST_HELD: begin
                  // Any low row counts as "still pressed"; extra keys in
                  // this column are deliberately ignored.
                  if (!any_low) begin
                     match_cnt <= MW'(1);
                     state     <= ST_RELEASE;
                  end
               end

               ST_RELEASE: begin
                  if (!any_low) begin
                     if (match_inc == MATCH_DONE) begin
                        key_held  <= 1'b0;
                        match_cnt <= '0;
                        state     <= ST_SCAN;
                        col_idx   <= col_next;
                        col_drive <= col_mask(col_next);
                     end else begin
                        match_cnt <= match_inc;
                     end
                  end else begin
                     match_cnt <= '0;
                     state     <= ST_HELD;
                  end
               end

               default: begin
                  state <= ST_SCAN;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner.
// A key matrix model turns pressed keys into row_in from col_drive. A
// behavioural reference (sample every DWELL cycles, two-cycle row delay,
// streak counting) predicts the outputs, and one compare process checks
// them on every falling edge. Directed literal checks pin the reference.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int DWELL = 4;
   localparam int DBC   = 3;

   logic        slow_clock = 1'b0;
   logic        reset      = 1'b1;
   logic [3:0]  row_in;
   logic [3:0]  col_drive;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   scan_state_e state_dbg;

   logic [15:0] key_down = '0;

   int checks    = 0;
   int errors    = 0;
   int valid_cnt = 0;

   // Reference model state
   int         m_col      = 0;
   int         m_phase    = 0;
   int         m_streak   = 0;
   int         m_rel      = 0;
   bit         m_locked   = 1'b0;
   bit         m_accepted = 1'b0;
   bit         m_valid    = 1'b0;
   logic [3:0] m_cand     = 4'h0;
   logic [3:0] m_code     = 4'h0;
   logic [3:0] m_hist [2] = '{4'hF, 4'hF};

   always #5 slow_clock = ~slow_clock;

   keypad_scanner #(
      .DWELL_CYCLES   (DWELL),
      .DEBOUNCE_COUNT (DBC)
   ) dut (
      .slow_clock (slow_clock),
      .reset      (reset),
      .row_in     (row_in),
      .col_drive  (col_drive),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_held   (key_held),
      .state_dbg  (state_dbg)
   );

   // Key matrix: a pressed key pulls its row low only while its column is driven.
   always_comb begin
      row_in = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!col_drive[c] && key_down[c*4+r]) row_in[r] = 1'b0;
         end
      end
   end

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_cols(input int c);
      logic [3:0] v;
      v = 4'hF;
      v[c] = 1'b0;
      return v;
   endfunction

   task automatic model_reset();
      m_col = 0; m_phase = 0; m_streak = 0; m_rel = 0;
      m_locked = 1'b0; m_accepted = 1'b0; m_valid = 1'b0;
      m_cand = 4'h0; m_code = 4'h0;
      m_hist[0] = 4'hF; m_hist[1] = 4'hF;
   endtask

   // Predict outputs after the next rising edge, given row_in at that edge.
   task automatic model_step(input logic [3:0] r);
      logic [3:0] seen;
      bit         low;
      int         row;
      int         code;
      seen      = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = r;
      m_valid   = 1'b0;
      if (m_phase == DWELL - 1) begin
         low = (seen != 4'hF);
         row = 0;
         for (int i = 3; i >= 0; i--) if (!seen[i]) row = i;
         code = m_col * 4 + row;
         if (!m_locked) begin
            if (low) begin
               m_locked = 1'b1; m_cand = 4'(code); m_streak = 1;
            end else begin
               m_col = (m_col + 1) % 4;
            end
         end else if (!m_accepted) begin
            if (low && 4'(code) == m_cand) begin
               m_streak++;
               if (m_streak == DBC) begin
                  m_accepted = 1'b1; m_code = m_cand; m_valid = 1'b1; m_rel = 0;
               end
            end else begin
               m_locked = 1'b0;
               m_col = (m_col + 1) % 4;
            end
         end else begin
            if (!low) begin
               m_rel++;
               if (m_rel == DBC) begin
                  m_accepted = 1'b0; m_locked = 1'b0; m_rel = 0;
                  m_col = (m_col + 1) % 4;
               end
            end else begin
               m_rel = 0;
            end
         end
      end
      m_phase = (m_phase + 1) % DWELL;
   endtask

   // Compare process: outputs are stable at the falling edge.
   always @(negedge slow_clock) begin
      if (reset) model_reset();
      check_val("cmp_col_drive", col_drive, exp_cols(m_col));
      check_val("cmp_key_code",  key_code,  m_code);
      check_val("cmp_key_valid", key_valid, m_valid);
      check_val("cmp_key_held",  key_held,  m_accepted);
      if (key_valid) valid_cnt++;
      if (!reset) model_step(row_in);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge slow_clock);
         #1;
      end
   endtask

   task automatic wait_valid_cnt(input int target, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (valid_cnt >= target) break;
         tick(1);
      end
      check_val(name, valid_cnt, target);
   endtask

   task automatic wait_locked(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (m_locked) break;
      end
      check_val(name, m_locked, 1);
   endtask

   logic [3:0] idle_tbl [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

   initial begin
      tick(3);
      check_val("rst_col_drive", col_drive, 4'b1110);
      check_val("rst_key_code",  key_code,  4'h0);
      check_val("rst_key_valid", key_valid, 1'b0);
      check_val("rst_key_held",  key_held,  1'b0);
      check_val("rst_state",     state_dbg, ST_SCAN);
      reset = 1'b0;

      // Idle scan: each column for DWELL cycles, wrapping back to column 0.
      for (int i = 0; i < 20; i++) begin
         check_val("idle_col_drive", col_drive, idle_tbl[i/4]);
         tick(1);
      end
      check_val("idle_no_valid", valid_cnt, 0);

      // Steady press at column 1, row 2.
      key_down[6] = 1'b1;
      wait_valid_cnt(1, 100, "press_accept");
      tick(8);
      check_val("press_key_code", key_code,  4'h6);
      check_val("press_key_held", key_held,  1'b1);
      check_val("press_frozen",   col_drive, 4'b1101);
      tick(24);
      check_val("press_still_frozen", col_drive, 4'b1101);
      check_val("press_one_pulse",    valid_cnt, 1);

      // One-sample release glitch while held.
      key_down[6] = 1'b0;
      tick(DWELL);
      key_down[6] = 1'b1;
      tick(16);
      check_val("glitch_held",     key_held,  1'b1);
      check_val("glitch_no_pulse", valid_cnt, 1);

      // Full release.
      key_down[6] = 1'b0;
      tick(20);
      check_val("release_held", key_held, 1'b0);
      check_val("release_code", key_code, 4'h6);

      // Bounce: low for a single sample point then gone.
      key_down[6] = 1'b1;
      wait_locked(40, "bounce_lock");
      key_down[6] = 1'b0;
      tick(DWELL);
      check_val("bounce_resume_col2", col_drive, 4'b1011);
      check_val("bounce_no_pulse",    valid_cnt, 1);
      check_val("bounce_code_kept",   key_code,  4'h6);

      // Two keys in column 2, rows 1 and 3: row 1 wins.
      key_down[9]  = 1'b1;
      key_down[11] = 1'b1;
      wait_valid_cnt(2, 100, "two_key_accept");
      tick(8);
      check_val("two_key_code", key_code,  4'h9);
      check_val("two_key_held", key_held,  1'b1);
      check_val("two_key_cols", col_drive, 4'b1011);
      check_val("two_key_state", state_dbg, ST_HELD);

      // Reset while held: outputs clear before the next edge.
      reset = 1'b1;
      #1;
      check_val("midrst_col_drive", col_drive, 4'b1110);
      check_val("midrst_key_code",  key_code,  4'h0);
      check_val("midrst_key_valid", key_valid, 1'b0);
      check_val("midrst_key_held",  key_held,  1'b0);
      check_val("midrst_state",     state_dbg, ST_SCAN);
      tick(2);
      reset = 1'b0;
      tick(15);
      check_val("postrst_no_early_pulse", valid_cnt, 2);
      wait_valid_cnt(3, 60, "postrst_reaccept");
      tick(2);
      check_val("postrst_code", key_code, 4'h9);
      check_val("postrst_held", key_held, 1'b1);

      key_down = '0;
      tick(24);
      check_val("final_released", key_held, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
